// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run sequencer placed in front of the CPU top level.
// Accepts a program-run request (valid/ready), holds cpu_start high for
// START_CYCLES cycles, then counts RUN cycles until cpu_done, a timeout or an
// abort, and returns the cycle count and status over a second valid/ready pair.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : run request handshake, req_prog = program to run
//   abort                 : terminate the current run (ignored in REPORT)
//   cpu_start, cpu_prog   : CPU start/reset and program select (registered)
//   cpu_done              : CPU completion flag
//   rsp_valid/rsp_ready   : result handshake
//   rsp_cycles            : RUN cycles elapsed
//   rsp_status            : 00 done, 01 timeout, 10 aborted
//   rsp_prog              : program the result belongs to
//   busy                  : controller is not idle
//   stat_runs, stat_timeouts : saturating response counters, only present
//                              when RUN_CTRL_STATS_EN is defined
module cpu_run_ctrl #(
  parameter int START_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 32'h0000_FFFF,
  parameter int PROG_W       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PROG_W-1:0] req_prog,
  input  logic              abort,
  output logic              cpu_start,
  output logic [PROG_W-1:0] cpu_prog,
  input  logic              cpu_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CNT_W-1:0]  rsp_cycles,
  output logic [1:0]        rsp_status,
  output logic [PROG_W-1:0] rsp_prog,
  output logic              busy
`ifdef RUN_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_runs,
  output logic [CNT_W-1:0]  stat_timeouts
`endif
);

  localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SC_W-1:0]  START_LOAD   = SC_W'(START_CYCLES - 1);
  localparam logic [SC_W-1:0]  SC_ZERO      = {SC_W{1'b0}};
  localparam logic [SC_W-1:0]  SC_ONE       = {{(SC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT  = CNT_W'(TIMEOUT);

  localparam logic [1:0] ST_DONE    = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_START  = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_t;

  state_t             state_r, state_nx_s;
  logic [SC_W-1:0]    start_cnt_r, start_cnt_nx_s;
  logic [CNT_W-1:0]   cycle_cnt_r, cycle_cnt_nx_s;
  logic               cpu_start_nx_s;
  logic [PROG_W-1:0]  cpu_prog_nx_s;
  logic               rsp_valid_nx_s;
  logic [CNT_W-1:0]   rsp_cycles_nx_s;
  logic [1:0]         rsp_status_nx_s;
  logic [PROG_W-1:0]  rsp_prog_nx_s;

  // Handshake-facing status: the only combinational outputs.
  assign req_ready = (state_r == S_IDLE) && !reset;
  assign busy      = (state_r != S_IDLE);

  // Next-state and next-output logic for the run sequencer.
  always_comb begin
    state_nx_s      = state_r;
    start_cnt_nx_s  = start_cnt_r;
    cycle_cnt_nx_s  = cycle_cnt_r;
    cpu_start_nx_s  = cpu_start;
    cpu_prog_nx_s   = cpu_prog;
    rsp_valid_nx_s  = rsp_valid;
    rsp_cycles_nx_s = rsp_cycles;
    rsp_status_nx_s = rsp_status;
    rsp_prog_nx_s   = rsp_prog;
    case (state_r)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          cpu_prog_nx_s  = req_prog;
          rsp_prog_nx_s  = req_prog;
          start_cnt_nx_s = START_LOAD;
          cpu_start_nx_s = 1'b1;
          state_nx_s     = S_START;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_START: begin
        // cpu_done is deliberately not looked at here: the CPU is still in reset.
        if (abort) begin
          cpu_start_nx_s  = 1'b0;
          rsp_valid_nx_s  = 1'b1;
          rsp_status_nx_s = ST_ABORT;
          rsp_cycles_nx_s = CNT_ZERO;
          state_nx_s      = S_REPORT;
        end else if (start_cnt_r == SC_ZERO) begin
          cpu_start_nx_s = 1'b0;
          cycle_cnt_nx_s = CNT_ZERO;
          state_nx_s     = S_RUN;
        end else begin
          start_cnt_nx_s = start_cnt_r - SC_ONE;
        end
      end
      S_RUN: begin
        // Priority abort > done > timeout; done on the last allowed cycle wins.
        if (abort) begin
          rsp_valid_nx_s  = 1'b1;
          rsp_status_nx_s = ST_ABORT;
          rsp_cycles_nx_s = cycle_cnt_r;
          state_nx_s      = S_REPORT;
        end else if (cpu_done) begin
          rsp_valid_nx_s  = 1'b1;
          rsp_status_nx_s = ST_DONE;
          rsp_cycles_nx_s = cycle_cnt_r;
          state_nx_s      = S_REPORT;
        end else if (cycle_cnt_r == TIMEOUT_LAST) begin
          rsp_valid_nx_s  = 1'b1;
          rsp_status_nx_s = ST_TIMEOUT;
          rsp_cycles_nx_s = TIMEOUT_CNT;
          state_nx_s      = S_REPORT;
        end else begin
          cycle_cnt_nx_s = cycle_cnt_r + CNT_ONE;
        end
      end
      S_REPORT: begin
        // rsp_valid is always high here, so rsp_ready alone completes the handshake.
        if (rsp_ready) begin
          rsp_valid_nx_s = 1'b0;
          state_nx_s     = S_IDLE;
        end else begin
          state_nx_s = S_REPORT;
        end
      end
      default: begin
        cpu_start_nx_s = 1'b0;
        rsp_valid_nx_s = 1'b0;
        state_nx_s     = S_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      start_cnt_r <= SC_ZERO;
      cycle_cnt_r <= CNT_ZERO;
      cpu_start   <= 1'b0;
      cpu_prog    <= {PROG_W{1'b0}};
      rsp_valid   <= 1'b0;
      rsp_cycles  <= CNT_ZERO;
      rsp_status  <= ST_DONE;
      rsp_prog    <= {PROG_W{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      start_cnt_r <= start_cnt_nx_s;
      cycle_cnt_r <= cycle_cnt_nx_s;
      cpu_start   <= cpu_start_nx_s;
      cpu_prog    <= cpu_prog_nx_s;
      rsp_valid   <= rsp_valid_nx_s;
      rsp_cycles  <= rsp_cycles_nx_s;
      rsp_status  <= rsp_status_nx_s;
      rsp_prog    <= rsp_prog_nx_s;
    end
  end

`ifdef RUN_CTRL_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic rsp_fire_s;
  assign rsp_fire_s = rsp_valid && rsp_ready;

  // Saturating counters of completed responses and of timeouts among them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_runs     <= CNT_ZERO;
      stat_timeouts <= CNT_ZERO;
    end else if (rsp_fire_s) begin
      if (stat_runs != CNT_MAX) begin
        stat_runs <= stat_runs + CNT_ONE;
      end
      if ((rsp_status == ST_TIMEOUT) && (stat_timeouts != CNT_MAX)) begin
        stat_timeouts <= stat_timeouts + CNT_ONE;
      end
    end
  end
`endif

endmodule
